// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry, host register map and fill FSM states
package fb_pkg;

  localparam int FB_WORDS = 9600;
  localparam int ADDR_W   = 15;

  localparam logic [14:0] PATTERN_ADDR = 15'h7FF0;
  localparam logic [14:0] CMD_ADDR     = 15'h7FF1;

  localparam int CMD_START = 0;
  localparam int CMD_ABORT = 1;
  localparam int CMD_SYNC  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VBL,
    ST_FILL,
    ST_DONE
  } fb_state_e;

endpackage

// File: rtl/fb_fill_ctrl.sv
// rtl/fb_fill_ctrl.sv - framebuffer fill engine sharing one write port with host pixel writes
module fb_fill_ctrl #(
  parameter int FB_WORDS = fb_pkg::FB_WORDS,
  parameter int ADDR_W   = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  input  logic              vblank,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [31:0]       fb_wdata,
  output logic              busy,
  output logic              done
);
  import fb_pkg::*;

  fb_state_e         r_state;
  fb_state_e         w_next;
  logic [ADDR_W-1:0] r_count;
  logic [31:0]       r_pattern;
  logic [31:0]       r_fill_data;
  logic              r_fb_we;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [31:0]       r_fb_wdata;

  logic w_host_wr;
  logic w_pix_wr;
  logic w_pat_wr;
  logic w_cmd_wr;
  logic w_start;
  logic w_abort;
  logic w_launch;
  logic w_fill_issue;
  logic w_last;

  assign w_host_wr    = chipselect && write;
  assign w_pix_wr     = w_host_wr && (address < ADDR_W'(FB_WORDS));
  assign w_pat_wr     = w_host_wr && (address == ADDR_W'(PATTERN_ADDR));
  assign w_cmd_wr     = w_host_wr && (address == ADDR_W'(CMD_ADDR));
  assign w_start      = w_cmd_wr && writedata[CMD_START];
  assign w_abort      = w_cmd_wr && writedata[CMD_ABORT];
  assign w_launch     = (r_state == ST_IDLE) && w_start && !w_abort;
  // Host pixel writes own the port; the fill only uses otherwise idle cycles.
  assign w_fill_issue = (r_state == ST_FILL) && !w_pix_wr && !w_abort;
  assign w_last       = (r_count == ADDR_W'(FB_WORDS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_next = writedata[CMD_SYNC] ? ST_WAIT_VBL : ST_FILL;
      end
      ST_WAIT_VBL: begin
        if (w_abort)     w_next = ST_IDLE;
        else if (vblank) w_next = ST_FILL;
      end
      ST_FILL: begin
        if (w_abort)                     w_next = ST_IDLE;
        else if (w_fill_issue && w_last) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_pattern   <= '0;
      r_fill_data <= '0;
      r_fb_we     <= 1'b0;
      r_fb_addr   <= '0;
      r_fb_wdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_pat_wr) r_pattern <= writedata;
      if (w_launch) begin
        r_fill_data <= r_pattern;
        r_count     <= '0;
      end else if (w_fill_issue && !w_last) begin
        r_count <= r_count + 1'b1;
      end
      r_fb_we <= w_pix_wr || w_fill_issue;
      if (w_pix_wr) begin
        r_fb_addr  <= address;
        r_fb_wdata <= writedata;
      end else if (w_fill_issue) begin
        r_fb_addr  <= r_count;
        r_fb_wdata <= r_fill_data;
      end else begin
        r_fb_addr  <= '0;
        r_fb_wdata <= '0;
      end
    end
  end

  assign fb_we    = r_fb_we;
  assign fb_addr  = r_fb_addr;
  assign fb_wdata = r_fb_wdata;
  assign busy     = (r_state == ST_WAIT_VBL) || (r_state == ST_FILL);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// tb/tb_fb_fill_ctrl.sv - scoreboard bench for fb_fill_ctrl
module tb_fb_fill_ctrl;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [14:0] address = '0;
  logic [31:0] writedata = '0;
  logic        vblank = 1'b0;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [31:0] fb_wdata;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  fb_fill_ctrl #(.FB_WORDS(FB_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .vblank(vblank),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .busy(busy), .done(done)
  );

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        host_q[$];
  exp_t        fill_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          fill_pops = 0;
  int          first_fill_cyc = -1;
  int          last_fill_cyc = -1;
  int          last_fill_addr = -1;
  int          done_cnt = 0;
  int          done_cyc = -1;
  logic [31:0] pat_model = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: host writes are matched by their due cycle, everything else must be the next fill word.
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      if (host_q.size() != 0 && host_q[0].cyc == cyc) begin
        chk("host_addr", 64'(fb_addr), 64'(host_q[0].addr));
        chk("host_data", 64'(fb_wdata), 64'(host_q[0].data));
        void'(host_q.pop_front());
      end else if (fill_q.size() != 0) begin
        chk("fill_addr", 64'(fb_addr), 64'(fill_q[0].addr));
        chk("fill_data", 64'(fb_wdata), 64'(fill_q[0].data));
        void'(fill_q.pop_front());
        fill_pops++;
        if (first_fill_cyc < 0) first_fill_cyc = cyc;
        last_fill_cyc  = cyc;
        last_fill_addr = int'(fb_addr);
      end else begin
        checks++;
        failures++;
        $display("FAIL unexpected_fb_we actual addr=%0d data=%0h required no write (cycle %0d)",
                 fb_addr, fb_wdata, cyc);
      end
    end
    if (host_q.size() != 0 && host_q[0].cyc <= cyc) begin
      checks++;
      failures++;
      $display("FAIL host_write_missing actual fb_we=%0b required addr=%0d data=%0h (cycle %0d)",
               fb_we, host_q[0].addr, host_q[0].data, cyc);
      void'(host_q.pop_front());
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [14:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    if (int'(a) < FB_WORDS) host_q.push_back('{cyc + 1, a, d});
    if (a == PATTERN_ADDR) pat_model = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic expect_fill();
    fill_q.delete();
    for (int i = 0; i < FB_WORDS; i++) fill_q.push_back('{0, 15'(i), pat_model});
    fill_pops      = 0;
    first_fill_cyc = -1;
    last_fill_cyc  = -1;
    last_fill_addr = -1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(busy), 64'(0));
  endtask

  task automatic wait_fill_addr(input string name, input int a, input int budget);
    int n = 0;
    while (last_fill_addr != a && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(last_fill_addr), 64'(a));
  endtask

  initial begin
    int k;
    int d0;

    // Reset state
    repeat (3) tick();
    chk("rst_fb_we", 64'(fb_we), 64'(0));
    chk("rst_fb_addr", 64'(fb_addr), 64'(0));
    chk("rst_fb_wdata", 64'(fb_wdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    reset = 1'b1;
    tick();

    // Host pixel writes in IDLE, including the last valid word and ignored addresses
    host_wr(15'd0, 32'hA5A5A5A5);
    host_wr(15'd9599, 32'h0000_0001);
    host_wr(15'd9600, 32'hDEAD_BEEF);
    host_wr(15'h5000, 32'hDEAD_BEEF);
    host_wr(15'h7FF2, 32'h0000_0001);
    repeat (3) tick();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_host_q_empty", 64'(host_q.size()), 64'(0));

    // Plain fill with pattern 0
    host_wr(PATTERN_ADDR, 32'h0);
    expect_fill();
    d0 = done_cnt;
    k  = cyc;
    host_wr(CMD_ADDR, 32'd1);
    chk("fill1_busy", 64'(busy), 64'(1));
    wait_idle("fill1_timeout", 12000);
    tick();
    chk("fill1_first_cyc", 64'(first_fill_cyc), 64'(k + 2));
    chk("fill1_span", 64'(last_fill_cyc - first_fill_cyc), 64'(FB_WORDS - 1));
    chk("fill1_words", 64'(fill_pops), 64'(FB_WORDS));
    chk("fill1_q_empty", 64'(fill_q.size()), 64'(0));
    chk("fill1_done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("fill1_done_cyc", 64'(done_cyc), 64'(last_fill_cyc));
    chk("fill1_done_low", 64'(done), 64'(0));
    chk("fill1_busy_low", 64'(busy), 64'(0));

    // Vblank-synchronised fill: nothing until vblank rises
    host_wr(PATTERN_ADDR, 32'h0F0F_0F0F);
    expect_fill();
    d0 = done_cnt;
    vblank = 1'b0;
    host_wr(CMD_ADDR, 32'd5);
    repeat (100) tick();
    chk("vbl_no_fill", 64'(fill_pops), 64'(0));
    chk("vbl_busy", 64'(busy), 64'(1));
    vblank = 1'b1;
    k = cyc;
    tick();
    vblank = 1'b0;
    wait_idle("fill2_timeout", 12000);
    tick();
    chk("fill2_first_cyc", 64'(first_fill_cyc), 64'(k + 2));
    chk("fill2_q_empty", 64'(fill_q.size()), 64'(0));
    chk("fill2_done_pulses", 64'(done_cnt - d0), 64'(1));

    // Vblank already high at entry, with host traffic, a PATTERN write and an ignored start
    host_wr(PATTERN_ADDR, 32'h3C3C_0001);
    expect_fill();
    d0 = done_cnt;
    vblank = 1'b1;
    k = cyc;
    host_wr(CMD_ADDR, 32'd5);
    for (int i = 0; i < 20000 && busy; i++) begin
      if (i % 4 == 0)   host_wr(15'd123, 32'hC0DE_0000 + 32'(i));
      else if (i == 1001) host_wr(PATTERN_ADDR, 32'hFFFF_FFFF);
      else if (i == 2002) host_wr(CMD_ADDR, 32'd1);
      else tick();
    end
    vblank = 1'b0;
    chk("fill3_timeout", 64'(busy), 64'(0));
    repeat (2) tick();
    chk("fill3_first_cyc", 64'(first_fill_cyc), 64'(k + 3));
    chk("fill3_slower", 64'(last_fill_cyc - first_fill_cyc > FB_WORDS - 1), 64'(1));
    chk("fill3_q_empty", 64'(fill_q.size()), 64'(0));
    chk("fill3_host_q_empty", 64'(host_q.size()), 64'(0));
    chk("fill3_done_pulses", 64'(done_cnt - d0), 64'(1));

    // Abort at counter 500; the new pattern takes effect here
    expect_fill();
    d0 = done_cnt;
    host_wr(CMD_ADDR, 32'd1);
    wait_fill_addr("abort_reach", 499, 2000);
    host_wr(CMD_ADDR, 32'd2);
    repeat (20) tick();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
    chk("abort_last_addr_ok", 64'(last_fill_addr <= 500), 64'(1));
    chk("abort_words_ok", 64'(fill_pops <= 501), 64'(1));
    fill_q.delete();
    host_wr(15'd42, 32'h0000_4242);
    repeat (4) tick();

    // Reset at counter 3000, then restart from 0 with the reset PATTERN
    host_wr(PATTERN_ADDR, 32'h1234_5678);
    expect_fill();
    d0 = done_cnt;
    host_wr(CMD_ADDR, 32'd1);
    wait_fill_addr("reset_reach", 2999, 4000);
    reset = 1'b0;
    tick();
    chk("midrst_fb_we", 64'(fb_we), 64'(0));
    chk("midrst_fb_addr", 64'(fb_addr), 64'(0));
    chk("midrst_fb_wdata", 64'(fb_wdata), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    reset = 1'b1;
    pat_model = '0;
    chk("midrst_words", 64'(fill_pops), 64'(3000));
    fill_q.delete();
    repeat (10) tick();
    chk("midrst_no_done", 64'(done_cnt - d0), 64'(0));
    expect_fill();
    host_wr(CMD_ADDR, 32'd1);
    wait_idle("fill5_timeout", 12000);
    tick();
    chk("fill5_words", 64'(fill_pops), 64'(FB_WORDS));
    chk("fill5_q_empty", 64'(fill_q.size()), 64'(0));
    chk("fill5_done_pulses", 64'(done_cnt - d0), 64'(1));

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_fill_ctrl.md
FB_FILL_CTRL -- requirements
Module: fb_fill_ctrl

Interface
REQ-001 Parameter FB_WORDS, default 9600: framebuffer depth in 32-bit words (640x480 at 1 bpp, bit n of a word = pixel x%32 == n).
REQ-002 Parameter ADDR_W, default 15: host and framebuffer address width.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 chipselect  input  1  host bus select.
REQ-006 write  input  1  host write strobe; valid only with chipselect=1.
REQ-007 address  input  ADDR_W  host word address.
REQ-008 writedata  input  32  host write data.
REQ-009 vblank  input  1  high during the display's vertical blanking interval.
REQ-010 fb_we  output  1  framebuffer write enable.
REQ-011 fb_addr  output  ADDR_W  framebuffer word address.
REQ-012 fb_wdata  output  32  framebuffer write data.
REQ-013 busy  output  1  high while in WAIT_VBL or FILL.
REQ-014 done  output  1  one-cycle pulse on fill completion.

Function
REQ-015 Host map: 0..FB_WORDS-1 = pixel words; 15'h7FF0 = PATTERN register; 15'h7FF1 = CMD (bit0 start, bit1 abort, bit2 sync-to-vblank); all other addresses are ignored.
REQ-016 A host write is one cycle with chipselect=1 and write=1; a host pixel write appears on fb_we/fb_addr/fb_wdata exactly 1 cycle later (registered outputs).
REQ-017 Host pixel writes have absolute priority; they are never stalled or dropped, and the block has no waitrequest.
REQ-018 FSM states: IDLE, WAIT_VBL, FILL, DONE.
REQ-019 IDLE: a CMD write with bit0=1 latches PATTERN into the fill-data register, clears the word counter to 0, and moves to WAIT_VBL if bit2=1, else to FILL.
REQ-020 WAIT_VBL: move to FILL on the first cycle with vblank=1; vblank already high at entry moves to FILL on the next cycle.
REQ-021 FILL: on each cycle with no host pixel write, issue fb_we with fb_addr=counter and fb_wdata=latched pattern, then increment the counter; on a host-write cycle the counter holds.
REQ-022 FILL to DONE after issuing word FB_WORDS-1; DONE asserts done for one cycle, then returns to IDLE.
REQ-023 A CMD write with bit1=1 in WAIT_VBL or FILL returns the FSM to IDLE next cycle with no done pulse; abort takes precedence over start in the same write.
REQ-024 A start command while busy=1 is ignored.
REQ-025 PATTERN writes during a fill take effect only at the next start.
REQ-026 A host pixel write during FILL is allowed; the fill may later overwrite that word (software responsibility).
REQ-027 Counter width is ADDR_W; the counter never exceeds FB_WORDS-1 and does not wrap.
REQ-028 Minimum fill time with no host traffic is FB_WORDS cycles from FILL entry to the last fb_we.

Reset
REQ-029 While reset=0 at a clock edge: state=IDLE, counter=0, PATTERN=0, and fb_we, fb_addr, fb_wdata, busy and done are all 0.
REQ-030 Reset asserted mid-fill aborts the fill immediately; no done pulse and no further fb_we until a new start.

Structure
REQ-031 Package fb_pkg holds FB_WORDS, ADDR_W, the PATTERN/CMD addresses, the CMD bit indices and the FSM state enum; it is shared with the display block.
REQ-032 Single module with no sub-module; the FSM, counter and output mux are inline.

Verification
REQ-033 Host writes 32'hA5A5A5A5 to address 0 in IDLE -> fb_we=1, fb_addr=0, fb_wdata=32'hA5A5A5A5 one cycle later.
REQ-034 PATTERN=0, CMD=1 with no host traffic -> 9600 consecutive fb_we at addresses 0..9599, then done high for 1 cycle, then busy=0.
REQ-035 CMD=5 with vblank held 0 for 100 cycles, then vblank=1 -> no fb_we for those 100 cycles, fill begins the cycle after vblank rises.
REQ-036 Fill running and host writes address 123 every 4th cycle -> every host write appears unstalled, every fill address appears exactly once, and the total fill takes more than 9600 cycles.
REQ-037 CMD=2 at counter 500 -> FSM reaches IDLE, no done pulse, no fb_we past address 500 except host writes.
REQ-038 reset=0 for 1 cycle at counter 3000 -> all outputs 0, then CMD=1 restarts the fill from address 0.
